// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver.
// Bytes are captured on the rising edge of RX_VALID and read out with a one-byte-per-request handshake.
module uart_rx_fifo #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    input  logic              RD_EN,
    output logic [7:0]        RD_DATA,
    output logic              RD_VALID,
    output logic              EMPTY,
    output logic              FULL,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERRUN,
    input  logic              OVERRUN_CLR
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic [7:0]        mem_q [DEPTH];

    logic              rx_valid_q, rx_valid_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overrun_q, overrun_d;

    logic              empty, full;
    logic              wr_req, wr_acc, rd_acc, ovr_set;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A read in the same cycle frees a slot, so a full FIFO can still take the write.
    assign wr_req  = RX_VALID & ~rx_valid_q;
    assign rd_acc  = RD_EN & ~empty;
    assign wr_acc  = wr_req & (~full | rd_acc);
    assign ovr_set = wr_req & full & ~rd_acc;

    always_comb begin
        rx_valid_d = RX_VALID;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overrun_d  = overrun_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // Set has priority over clear so a fresh drop is never masked.
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (OVERRUN_CLR) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= RX_DATA;
        end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign EMPTY    = empty;
    assign FULL     = full;
    assign COUNT    = count_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; expected bytes travel through a queue scoreboard.
module tb_uart_rx_fifo;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic            CLK;
    logic            RESET_N;
    logic [7:0]      RX_DATA;
    logic            RX_VALID;
    logic            RD_EN;
    logic [7:0]      RD_DATA;
    logic            RD_VALID;
    logic            EMPTY;
    logic            FULL;
    logic [ADDR_W:0] COUNT;
    logic            OVERRUN;
    logic            OVERRUN_CLR;

    uart_rx_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .RX_DATA     (RX_DATA),
        .RX_VALID    (RX_VALID),
        .RD_EN       (RD_EN),
        .RD_DATA     (RD_DATA),
        .RD_VALID    (RD_VALID),
        .EMPTY       (EMPTY),
        .FULL        (FULL),
        .COUNT       (COUNT),
        .OVERRUN     (OVERRUN),
        .OVERRUN_CLR (OVERRUN_CLR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int        n_checks = 0;
    int        n_pass   = 0;
    logic [7:0] exp_q [$];
    logic       exp_ovr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_level(input string tag);
        check({tag, "_count"}, 32'(COUNT), 32'(exp_q.size()));
        check({tag, "_empty"}, 32'(EMPTY), 32'(exp_q.size() == 0));
        check({tag, "_full"},  32'(FULL),  32'(exp_q.size() == DEPTH));
    endtask

    // One isolated rising edge on RX_VALID, then back low.
    task automatic write_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr = 1'b1;
        tick();
    endtask

    // Holds RD_EN for n cycles and checks each returned byte against the scoreboard.
    task automatic read_burst(input int n, input string tag);
        logic [7:0] e;
        RD_EN = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_valid"}, 32'(RD_VALID), 32'd1);
                check({tag, "_data"},  32'(RD_DATA),  32'(e));
            end else begin
                check({tag, "_novalid"}, 32'(RD_VALID), 32'd0);
            end
        end
        RD_EN = 1'b0;
        tick();
        check({tag, "_done_valid"}, 32'(RD_VALID), 32'd0);
    endtask

    logic [7:0] e;
    logic [7:0] d;

    initial begin
        RESET_N     = 1'b0;
        RX_DATA     = 8'h00;
        RX_VALID    = 1'b0;
        RD_EN       = 1'b0;
        OVERRUN_CLR = 1'b0;
        #3;
        check_level("rst");
        check("rst_rd_valid", 32'(RD_VALID), 32'd0);
        check("rst_rd_data",  32'(RD_DATA),  32'h00);
        check("rst_overrun",  32'(OVERRUN),  32'd0);
        #4 RESET_N = 1'b1;

        // 1: single byte round trip
        write_byte(8'hA5);
        check_level("t1_wr");
        read_burst(1, "t1_rd");
        check_level("t1_after");

        // 2: long strobe writes once
        RX_DATA  = 8'h3C;
        RX_VALID = 1'b1;
        repeat (5) tick();
        RX_VALID = 1'b0;
        exp_q.push_back(8'h3C);
        tick();
        check_level("t2_hold");
        read_burst(1, "t2_rd");

        // 3: fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
        check_level("t3_full");
        write_byte(8'hFF);
        check("t3_overrun", 32'(OVERRUN), 32'(exp_ovr));
        check_level("t3_drop");
        read_burst(DEPTH, "t3_drain");
        check_level("t3_empty");
        check("t3_ovr_sticky", 32'(OVERRUN), 32'd1);
        OVERRUN_CLR = 1'b1;
        tick();
        OVERRUN_CLR = 1'b0;
        exp_ovr = 1'b0;
        check("t3_ovr_clr", 32'(OVERRUN), 32'd0);

        // read while empty is ignored
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        check("rd_empty_valid", 32'(RD_VALID), 32'd0);
        check_level("rd_empty");

        // 4: write+read while full
        for (int i = 0; i < DEPTH; i++) write_byte(8'h10 + 8'(i));
        check_level("t4_full");
        RX_DATA  = 8'h55;
        RX_VALID = 1'b1;
        RD_EN    = 1'b1;
        tick();
        RX_VALID = 1'b0;
        RD_EN    = 1'b0;
        e = exp_q.pop_front();
        exp_q.push_back(8'h55);
        check("t4_valid",   32'(RD_VALID), 32'd1);
        check("t4_data",    32'(RD_DATA),  32'(e));
        check("t4_overrun", 32'(OVERRUN),  32'd0);
        check_level("t4_swap");
        tick();
        // overrun set wins against a simultaneous clear
        RX_DATA     = 8'hEE;
        RX_VALID    = 1'b1;
        OVERRUN_CLR = 1'b1;
        tick();
        RX_VALID    = 1'b0;
        OVERRUN_CLR = 1'b0;
        check("t4_set_wins", 32'(OVERRUN), 32'd1);
        check_level("t4_drop");
        read_burst(DEPTH, "t4_drain");
        OVERRUN_CLR = 1'b1;
        tick();
        OVERRUN_CLR = 1'b0;

        // write and read together while empty: no bypass
        RX_DATA  = 8'h77;
        RX_VALID = 1'b1;
        RD_EN    = 1'b1;
        tick();
        RX_VALID = 1'b0;
        RD_EN    = 1'b0;
        exp_q.push_back(8'h77);
        check("nobypass_valid", 32'(RD_VALID), 32'd0);
        check_level("nobypass");
        read_burst(1, "nobypass_rd");

        // 5: pointer wrap
        d = 8'h80;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                write_byte(d);
                d = d + 8'd1;
            end
            check_level("t5_fill");
            read_burst(10, "t5_rd");
            check_level("t5_round");
        end

        // 6: async reset mid-cycle discards contents and in-flight read
        for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        e = exp_q.pop_front();
        check("t6_pre_valid", 32'(RD_VALID), 32'd1);
        check("t6_pre_data",  32'(RD_DATA),  32'(e));
        #1 RESET_N = 1'b0;
        #1;
        exp_q.delete();
        check_level("t6_rst");
        check("t6_rst_valid", 32'(RD_VALID), 32'd0);
        check("t6_rst_data",  32'(RD_DATA),  32'h00);
        RESET_N = 1'b1;
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        check("t6_post_valid", 32'(RD_VALID), 32'd0);
        check_level("t6_post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
